// File: rtl/mod16_pkg.sv
// Shared definitions for the mod-16 PWM stage: default widths, range limits,
// the controller state encoding and width-generic helpers for the limits.
// No ports; imported by the stage top and its duty shadow sub-block.
package mod16_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int PCNT_W_DEF = 8;

  // Largest count value and largest legal duty for the default count width.
  localparam int CNT_MAX  = 2**CNT_W_DEF - 1;
  localparam int DUTY_MAX = 2**CNT_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Width-generic forms of the limits above, for parameterised instances.
  function automatic int cnt_max(input int w);
    return (2**w) - 1;
  endfunction

  function automatic int duty_max(input int w);
    return 2**w;
  endfunction

endpackage

// File: rtl/mod16_pwm_stage_if.sv
// Duty-value handshake between a duty source and the PWM stage.
// Ports: duty_data (CNT_W+1 bits, high cycles per period), duty_valid, duty_ready.
// A transfer happens on any cycle with duty_valid && duty_ready.
interface mod16_pwm_stage_if #(
  parameter int CNT_W = 4
);

  logic [CNT_W:0] duty_data;
  logic           duty_valid;
  logic           duty_ready;

  modport master (
    output duty_data,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_data,
    input  duty_valid,
    output duty_ready
  );

endinterface

// File: rtl/mod16_pwm_stage_duty_shadow.sv
// Double buffer for the PWM duty: a one-entry pending slot fed by the handshake,
// and the active value used by the compare. Ports: clk, reset, duty_if (slave),
// promote_i (move pending to active this cycle), duty_eff_o (duty the compare uses now).
// Latency: duty_eff_o shows a promoted value in the promote cycle itself (combinational
// bypass). Backpressure: duty_ready is low whenever the pending slot is occupied.
module pwm_duty_shadow
  import mod16_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  mod16_pwm_stage_if.slave  duty_if,
  input  logic              promote_i,
  output logic [CNT_W:0]    duty_eff_o
);

  localparam logic [CNT_W:0] DUTY_TOP = (CNT_W+1)'(duty_max(CNT_W));

  logic [CNT_W:0] pend_q, pend_d;
  logic           pend_vld_q, pend_vld_d;
  logic [CNT_W:0] act_q, act_d;
  logic [CNT_W:0] duty_clamped;
  logic           take;
  logic           move;

  assign duty_if.duty_ready = !pend_vld_q;

  assign duty_clamped = (duty_if.duty_data > DUTY_TOP) ? DUTY_TOP : duty_if.duty_data;

  // take and move never coincide: take needs an empty slot, move needs a full one.
  // A value taken in a promote cycle therefore waits for the next promote.
  assign take = duty_if.duty_valid && !pend_vld_q;
  assign move = promote_i && pend_vld_q;

  // Bypass so the compare in the promote cycle already sees the new duty.
  assign duty_eff_o = move ? pend_q : act_q;

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    act_d      = act_q;
    if (move) begin
      act_d      = pend_q;
      pend_vld_d = 1'b0;
    end
    if (take) begin
      pend_d     = duty_clamped;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      act_q      <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      act_q      <= act_d;
    end
  end

endmodule

// File: rtl/mod16_pwm_stage.sv
// PWM stage behind a free-running mod-2**CNT_W counter: compares the count against a
// double-buffered duty, reports period boundaries, tallies periods and flags count breaks.
// Ports: clk, reset (sync, active-high), cnt_in, en, duty_if (slave handshake), pwm,
// period_done, period_count, seq_err (sticky), busy. pwm/period_done lag the count by 1 clk;
// duty_ready drops while a new duty waits for the next period boundary.
module mod16_pwm_stage
  import mod16_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PCNT_W = PCNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              en,
  mod16_pwm_stage_if.slave  duty_if,
  output logic              pwm,
  output logic              period_done,
  output logic [PCNT_W-1:0] period_count,
  output logic              seq_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    prev_cnt_q;
  logic                pwm_q, pwm_d;
  logic                pdone_q, pdone_d;
  logic [PCNT_W-1:0]   pcount_q, pcount_d;
  logic                seq_err_q, seq_err_d;

  logic                boundary;
  logic                in_period;
  logic                sync_start;
  logic                drain_exit;
  logic                active;
  logic                promote;
  logic                cnt_break;
  logic [CNT_W-1:0]    cnt_expect;
  logic [CNT_W:0]      duty_eff;

  assign boundary   = (cnt_in == '0) && (prev_cnt_q == CNT_TOP);
  assign in_period  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // Any zero count starts the run; no preceding wrap is needed.
  assign sync_start = (state_q == ST_SYNC) && en && (cnt_in == '0);
  // The boundary that ends a drain already belongs to the next period.
  assign drain_exit = (state_q == ST_DRAIN) && !en && boundary;
  assign active     = sync_start || (state_q == ST_RUN) ||
                      ((state_q == ST_DRAIN) && !drain_exit);
  // Idle takes a new duty at once; otherwise only at a period start.
  assign promote    = (state_q == ST_IDLE) || sync_start || boundary;

  assign cnt_expect = prev_cnt_q + CNT_ONE;
  assign cnt_break  = (cnt_in != cnt_expect);

  pwm_duty_shadow #(
    .CNT_W (CNT_W)
  ) u_duty_shadow (
    .clk        (clk),
    .reset      (reset),
    .duty_if    (duty_if),
    .promote_i  (promote),
    .duty_eff_o (duty_eff)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_SYNC;
      ST_SYNC: begin
        if (!en)               state_d = ST_IDLE;
        else if (cnt_in == '0) state_d = ST_RUN;
      end
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en)            state_d = ST_RUN;
        else if (boundary) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pwm_d     = active && ({1'b0, cnt_in} < duty_eff);
    pdone_d   = boundary && in_period;
    pcount_d  = pcount_q;
    if (pdone_d) begin
      pcount_d = pcount_q + PCNT_ONE;
    end
    seq_err_d = seq_err_q || (in_period && cnt_break);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_cnt_q <= '0;
      pwm_q      <= 1'b0;
      pdone_q    <= 1'b0;
      pcount_q   <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_cnt_q <= cnt_in;
      pwm_q      <= pwm_d;
      pdone_q    <= pdone_d;
      pcount_q   <= pcount_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign pwm          = pwm_q;
  assign period_done  = pdone_q;
  assign period_count = pcount_q;
  assign seq_err      = seq_err_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mod16_pwm_stage.sv
// Bench for mod16_pwm_stage: directed per-cycle stimulus pushes hand-derived expected
// outputs into a queue; a monitor pops one entry after every clock edge and compares.
module tb_mod16_pwm_stage;
  import mod16_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cnt_in;
  logic       en;
  logic       pwm;
  logic       period_done;
  logic [7:0] period_count;
  logic       seq_err;
  logic       busy;

  always #5 clk = ~clk;

  mod16_pwm_stage_if #(.CNT_W(4)) dif ();

  mod16_pwm_stage #(
    .CNT_W  (4),
    .PCNT_W (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cnt_in       (cnt_in),
    .en           (en),
    .duty_if      (dif),
    .pwm          (pwm),
    .period_done  (period_done),
    .period_count (period_count),
    .seq_err      (seq_err),
    .busy         (busy)
  );

  typedef struct {
    bit         pwm;
    bit         pd;
    logic [7:0] pc;
    bit         se;
    bit         busy;
    bit         rdy;
    string      tag;
  } exp_t;

  exp_t       q[$];
  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [3:0] cnt_v;
  logic [7:0] pc_exp;
  bit         se_exp;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per clock edge, sampled 2 time units after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".pwm"},          {7'd0, pwm},         {7'd0, e.pwm});
        chk({e.tag, ".period_done"},  {7'd0, period_done}, {7'd0, e.pd});
        chk({e.tag, ".period_count"}, period_count,        e.pc);
        chk({e.tag, ".seq_err"},      {7'd0, seq_err},     {7'd0, e.se});
        chk({e.tag, ".busy"},         {7'd0, busy},        {7'd0, e.busy});
        chk({e.tag, ".duty_ready"},   {7'd0, dif.duty_ready}, {7'd0, e.rdy});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // One clock: drive cnt_v and the given inputs, then queue what must be seen after the edge.
  task automatic tick(input bit r, input bit e, input bit dv, input logic [4:0] dd,
                      input bit xp, input bit xpd, input bit xse, input bit xbusy,
                      input bit xrdy, input string tag);
    exp_t x;
    reset          = r;
    cnt_in         = cnt_v;
    en             = e;
    dif.duty_valid = dv;
    dif.duty_data  = dd;
    @(posedge clk);
    if (r)        pc_exp = 8'd0;
    else if (xpd) pc_exp = pc_exp + 8'd1;
    x.pwm  = xp;
    x.pd   = xpd;
    x.pc   = pc_exp;
    x.se   = xse;
    x.busy = xbusy;
    x.rdy  = xrdy;
    x.tag  = tag;
    q.push_back(x);
    cnt_v = cnt_v + 4'd1;
    @(negedge clk);
  endtask

  // Idle with en low until the counter sits at its top value, then raise en (IDLE->SYNC).
  task automatic start_run();
    while (cnt_v != 4'(CNT_MAX))
      tick(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, se_exp, 1'b0, 1'b1, "idle");
    tick(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, se_exp, 1'b1, 1'b1, "sync");
  endtask

  // One full counter period, cnt 0..15. pat[c] is the pwm seen after the edge at count c.
  // acc_at: count at which a new duty is offered (-1 none); en drops from count drop_at on.
  task automatic run_period(input bit first, input logic [15:0] pat, input int acc_at,
                            input logic [4:0] acc_dd, input int drop_at, input string tag);
    for (int c = 0; c < 16; c++) begin
      tick(1'b0, (c < drop_at), (c == acc_at), acc_dd,
           pat[c], ((c == 0) && !first), se_exp, 1'b1,
           !((acc_at >= 0) && (c >= acc_at)), tag);
    end
  endtask

  initial begin
    cnt_v          = 4'd0;
    pc_exp         = 8'd0;
    se_exp         = 1'b0;
    reset          = 1'b1;
    en             = 1'b0;
    cnt_in         = 4'd0;
    dif.duty_valid = 1'b0;
    dif.duty_data  = 5'd0;

    tick(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset0");
    tick(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset1");

    // Duty 8 loaded while idle: slot full for one cycle, then promoted.
    tick(1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "load8");
    tick(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "idle_promote");

    start_run();
    run_period(1'b1, 16'h00FF, -1, 5'd0, 16, "p1_duty8");
    run_period(1'b0, 16'h00FF, -1, 5'd0, 16, "p2_duty8");
    run_period(1'b0, 16'h00FF,  3, 5'd0, 16, "p3_duty8_acc0");
    run_period(1'b0, 16'h0000, 10, 5'(DUTY_MAX), 16, "p4_duty0_acc16");
    run_period(1'b0, 16'hFFFF,  2, 5'd20, 16, "p5_duty16_acc20");
    run_period(1'b0, 16'hFFFF,  1, 5'd12, 16, "p6_duty20_acc12");
    run_period(1'b0, 16'h0FFF,  6, 5'd4,  16, "p7_duty12_acc4");
    run_period(1'b0, 16'h000F, -1, 5'd0,  16, "p8_duty4");
    // Offered in the boundary cycle: held a whole period before it takes effect.
    run_period(1'b0, 16'h000F,  0, 5'd8,  16, "p9_duty4_acc8_at_boundary");
    // en drops at cnt 5: drain keeps the pattern through cnt 15.
    run_period(1'b0, 16'h00FF, -1, 5'd0,   5, "p10_drain");
    tick(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "drain_exit");
    tick(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "idle_after_drain");

    // Restart, then break the count sequence 7 -> 0.
    start_run();
    run_period(1'b1, 16'h00FF, -1, 5'd0, 16, "p11_restart");
    for (int c = 0; c < 8; c++)
      tick(1'b0, 1'b1, 1'b0, 5'd0, 1'b1, (c == 0), 1'b0, 1'b1, 1'b1, "pre_glitch");
    cnt_v  = 4'd0;
    se_exp = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "glitch");
    for (int c = 1; c < 16; c++)
      tick(1'b0, 1'b1, (c == 2), 5'(DUTY_MAX), (c < 8), 1'b0, 1'b1, 1'b1, !(c >= 2),
           "post_glitch");
    for (int c = 0; c < 9; c++)
      tick(1'b0, 1'b1, 1'b0, 5'd0, 1'b1, (c == 0), 1'b1, 1'b1, 1'b1, "full_duty");

    // Reset in the middle of a full-duty run at cnt 9.
    se_exp = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset_mid_run");
    tick(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "after_reset");

    repeat (3) @(negedge clk);
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
